// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : Time-multiplexed hex seven-segment driver with frame-aligned
//            updates, leading-zero blanking, PWM dimming and dead time.
//            Optional blinking is compiled in with `define SEVSEG_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 100,
  parameter int PWM_BITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
`ifdef SEVSEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
`ifdef SEVSEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  input  logic                  upd_valid,
  output logic                  upd_ready,
  output logic [6:0]            led_out,
  output logic                  led_dp,
  output logic [DIGITS-1:0]     led_sel,
  output logic                  frame_done
);

  localparam int                c_cnt_w    = $clog2(SCAN_DIV);
  localparam int                c_idx_w    = $clog2(DIGITS);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
  localparam logic [6:0]        c_seg_off  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              c_dp_off   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] c_sel_off  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_idx_w-1:0]  idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   dp_q;
  logic                blz_q;
  logic [6:0]          led_out_q, led_out_d;
  logic                led_dp_q, led_dp_d;
  logic [DIGITS-1:0]   led_sel_q, led_sel_d;
  logic                frame_done_q;

  logic                tick_w, fb_w, xfer_w, blink_off_w;
  logic [3:0]          dig_w [DIGITS];
  logic [3:0]          cur_dig_w;
  logic [6:0]          glyph_w;
  logic                nz_above_w, blank_w, lit_w;
  logic [DIGITS-1:0]   sel_act_w;

  assign tick_w    = (cnt_q == c_cnt_last);
  assign fb_w      = tick_w && (idx_q == c_idx_last);
  assign xfer_w    = upd_valid && fb_w;
  assign upd_ready = fb_w;

  assign cnt_d = tick_w ? '0 : cnt_q + 1'b1;
  assign idx_d = !tick_w ? idx_q : ((idx_q == c_idx_last) ? '0 : idx_q + 1'b1);
  // Cleared during the dead-time cycle so pwm==0 on the first lit cycle of a slot.
  assign pwm_d = (cnt_q == '0) ? '0 : pwm_q + 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign dig_w[i] = bcd_q[4*i +: 4];
  end

  assign cur_dig_w = dig_w[idx_q];

`ifdef SEVSEG_BLINK_EN
  localparam int c_fr_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_fr_w-1:0] c_fr_last = c_fr_w'(BLINK_FRAMES - 1);
  logic [c_fr_w-1:0] frame_cnt_q;
  logic              phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (fb_w) begin
      if (frame_cnt_q == c_fr_last) begin
        frame_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign blink_off_w = phase_q && blink_mask[idx_q];
`else
  assign blink_off_w = 1'b0;
`endif

  always_comb begin
    case (cur_dig_w)
      4'h0: glyph_w = 7'h3F;
      4'h1: glyph_w = 7'h06;
      4'h2: glyph_w = 7'h5B;
      4'h3: glyph_w = 7'h4F;
      4'h4: glyph_w = 7'h66;
      4'h5: glyph_w = 7'h6D;
      4'h6: glyph_w = 7'h7D;
      4'h7: glyph_w = 7'h07;
      4'h8: glyph_w = 7'h7F;
      4'h9: glyph_w = 7'h6F;
      4'hA: glyph_w = 7'h77;
      4'hB: glyph_w = 7'h7C;
      4'hC: glyph_w = 7'h39;
      4'hD: glyph_w = 7'h5E;
      4'hE: glyph_w = 7'h79;
      default: glyph_w = 7'h71;
    endcase
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    nz_above_w = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && dig_w[j] != 4'h0) nz_above_w = 1'b1;
    end
    blank_w = blz_q && (idx_q != '0) && !nz_above_w;
  end

  always_comb begin
    lit_w     = (brightness == {PWM_BITS{1'b1}}) || (pwm_q < brightness);
    sel_act_w = '0;
    if (lit_w && (cnt_q != '0) && !blink_off_w) sel_act_w[idx_q] = 1'b1;
    led_sel_d = sel_act_w ^ c_sel_off;
    led_out_d = (blank_w ? 7'h00 : glyph_w) ^ c_seg_off;
    led_dp_d  = dp_q[idx_q] ^ c_dp_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      bcd_q        <= '0;
      dp_q         <= '0;
      blz_q        <= 1'b0;
      led_out_q    <= c_seg_off;
      led_dp_q     <= c_dp_off;
      led_sel_q    <= c_sel_off;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      led_out_q    <= led_out_d;
      led_dp_q     <= led_dp_d;
      led_sel_q    <= led_sel_d;
      frame_done_q <= fb_w;
      if (xfer_w) begin
        bcd_q <= bcd_in;
        dp_q  <= dp_in;
        blz_q <= blank_lz;
      end
    end
  end

  assign led_out    = led_out_q;
  assign led_dp     = led_dp_q;
  assign led_sel    = led_sel_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Purpose  : Directed self-checking bench, 4 digits, 4-cycle slots, 2-bit PWM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [6:0]  led_out;
  logic        led_dp;
  logic [3:0]  led_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int k = 0;   // rising edges since reset release
  int fd_cnt;

  seven_segment_scanner #(
    .DIGITS(4), .SCAN_DIV(4), .PWM_BITS(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .led_out(led_out), .led_dp(led_dp), .led_sel(led_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  // Advance until outputs reflect slot state (digit d, cnt c) of the previous cycle.
  task automatic goto(input int d, input int c);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (((k - 1) % 16) == 4 * d + c) break;
    end
  endtask

  task automatic load(input logic [15:0] b, input logic [3:0] dp, input logic blz);
    bcd_in = b; dp_in = dp; blank_lz = blz; upd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((k % 16) == 15) break;
    end
    chk("load_ready", {15'd0, upd_ready}, 16'd1);
    tick();
    upd_valid = 1'b0; bcd_in = 16'hFFFF; dp_in = 4'hF; blank_lz = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sel", {12'd0, led_sel}, 16'h000F);
    chk("rst_out", {9'd0, led_out}, 16'h007F);
    chk("rst_dp", {15'd0, led_dp}, 16'd1);
    chk("rst_ready", {15'd0, upd_ready}, 16'd0);
    chk("rst_fd", {15'd0, frame_done}, 16'd0);
    rst_n = 1'b1; k = 0;

    // First select appears once the cnt==1 state has been registered
    tick();
    chk("sel_k1", {12'd0, led_sel}, 16'h000F);
    tick();
    chk("sel_k2", {12'd0, led_sel}, 16'h000E);
    chk("out_k2_zero", {9'd0, led_out}, 16'h0040);
    chk("dp_k2", {15'd0, led_dp}, 16'd1);

    // Handshake: upd_ready only at cnt=3, idx=3
    bcd_in = 16'h1234; upd_valid = 1'b1;
    chk("ready_k2", {15'd0, upd_ready}, 16'd0);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("ready_scan", {15'd0, upd_ready}, {15'd0, (k == 15)});
    end
    tick();
    upd_valid = 1'b0; bcd_in = 16'hFFFF;
    chk("fd_k16", {15'd0, frame_done}, 16'd1);
    chk("ready_k16", {15'd0, upd_ready}, 16'd0);
    tick();
    chk("fd_k17", {15'd0, frame_done}, 16'd0);
    goto(0, 1);
    chk("hs_d0_out", {9'd0, led_out}, 16'h0019);
    chk("hs_d0_sel", {12'd0, led_sel}, 16'h000E);
    goto(3, 1);
    chk("hs_d3_out", {9'd0, led_out}, 16'h0079);
    chk("hs_d3_sel", {12'd0, led_sel}, 16'h0007);
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (frame_done) fd_cnt++;
    end
    chk("fd_per_32", fd_cnt[15:0], 16'd2);
    goto(0, 1);
    chk("ignored_in", {9'd0, led_out}, 16'h0019);

    // Leading-zero blanking on and off
    load(16'h0070, 4'b0000, 1'b1);
    goto(0, 1); chk("lz_d0", {9'd0, led_out}, 16'h0040);
    goto(1, 1); chk("lz_d1", {9'd0, led_out}, 16'h0078);
    goto(2, 1); chk("lz_d2", {9'd0, led_out}, 16'h007F);
    goto(3, 1); chk("lz_d3", {9'd0, led_out}, 16'h007F);
    load(16'h0070, 4'b0000, 1'b0);
    goto(2, 1); chk("nolz_d2", {9'd0, led_out}, 16'h0040);
    goto(3, 1); chk("nolz_d3", {9'd0, led_out}, 16'h0040);

    // Brightness
    brightness = 2'd1;
    goto(0, 0); chk("b1_c0", {12'd0, led_sel}, 16'h000F);
    goto(0, 1); chk("b1_c1", {12'd0, led_sel}, 16'h000E);
    goto(0, 2); chk("b1_c2", {12'd0, led_sel}, 16'h000F);
    goto(0, 3); chk("b1_c3", {12'd0, led_sel}, 16'h000F);
    brightness = 2'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("b0_dark", {12'd0, led_sel}, 16'h000F);
    end
    brightness = 2'd3;
    goto(1, 0); chk("b3_c0", {12'd0, led_sel}, 16'h000F);
    goto(1, 1); chk("b3_c1", {12'd0, led_sel}, 16'h000D);
    goto(1, 2); chk("b3_c2", {12'd0, led_sel}, 16'h000D);
    goto(1, 3); chk("b3_c3", {12'd0, led_sel}, 16'h000D);

    // Hex glyphs and decimal point
    load(16'hFA08, 4'b0100, 1'b0);
    goto(0, 1); chk("hex_d0", {9'd0, led_out}, 16'h0000);
    chk("hex_d0_dp", {15'd0, led_dp}, 16'd1);
    goto(1, 1); chk("hex_d1", {9'd0, led_out}, 16'h0040);
    goto(2, 1); chk("hex_d2", {9'd0, led_out}, 16'h0008);
    chk("hex_d2_dp", {15'd0, led_dp}, 16'd0);
    goto(3, 1); chk("hex_d3", {9'd0, led_out}, 16'h000E);
    chk("hex_d3_dp", {15'd0, led_dp}, 16'd1);

    // Asynchronous reset while digit 2 is lit
    goto(2, 1);
    chk("pre_rst_sel", {12'd0, led_sel}, 16'h000B);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", {12'd0, led_sel}, 16'h000F);
    chk("arst_out", {9'd0, led_out}, 16'h007F);
    chk("arst_dp", {15'd0, led_dp}, 16'd1);
    chk("arst_ready", {15'd0, upd_ready}, 16'd0);
    chk("arst_fd", {15'd0, frame_done}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; k = 0;
    goto(0, 1);
    chk("post_d0_out", {9'd0, led_out}, 16'h0040);
    chk("post_d0_sel", {12'd0, led_sel}, 16'h000E);
    goto(2, 1);
    chk("post_d2_out", {9'd0, led_out}, 16'h0040);
    chk("post_d2_sel", {12'd0, led_sel}, 16'h000B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
